// File: rtl/cat_recognizer_pkg.sv
// Shared definitions for the cat recognizer datapath.
//   - Default datapath widths, matched by the upstream multiply-add block.
//   - Frame size shared with the upstream row sequencer.
//   - FSM state type for the score accumulator.
package cat_recognizer_pkg;

  localparam int DefPixelWidth  = 8;
  localparam int DefWeightWidth = 5;
  localparam int DefResultWidth = 2 * (DefWeightWidth + DefPixelWidth) + 1;
  localparam int DefAccWidth    = 32;

  // Number of row dot-products that make up one frame.
  localparam int DefNumProducts = 4096;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DECIDE = 2'd2
  } acc_state_e;

endpackage

// File: rtl/sat_adder.sv
// Combinational unsigned saturating adder.
//   a, b  : Width-bit unsigned operands
//   sum   : a + b, clamped to all-ones when the true sum does not fit
//   carry : 1 when the true sum exceeded 2^Width - 1 (i.e. sum was clamped)
module sat_adder #(
  parameter int Width = 32
) (
  input  logic [Width-1:0] a,
  input  logic [Width-1:0] b,
  output logic [Width-1:0] sum,
  output logic             carry
);

  logic [Width-1:0] raw_sum;

  assign {carry, raw_sum} = {1'b0, a} + {1'b0, b};
  assign sum              = carry ? '1 : raw_sum;

endmodule

// File: rtl/cat_score_accumulator.sv
// Frame score accumulator and cat / not-cat decision.
//   clk, rst       : clock, asynchronous active-low reset
//   start          : begin (or abort and restart) a frame
//   product_valid  : product is valid this cycle (only honoured in ACCUM)
//   product        : unsigned row dot-product from the multiply-add block
//   threshold      : unsigned decision threshold, sampled in DECIDE
//   busy           : high in ACCUM and DECIDE
//   done           : one-cycle pulse when score/is_cat/overflow update
//   score          : saturated frame score of the last completed frame
//   is_cat         : score >= threshold for the last completed frame
//   overflow       : the last completed frame saturated
module cat_score_accumulator
  import cat_recognizer_pkg::*;
#(
  parameter int PixelWidth  = DefPixelWidth,
  parameter int WeightWidth = DefWeightWidth,
  parameter int ResultWidth = 2 * (WeightWidth + PixelWidth) + 1,
  parameter int AccWidth    = DefAccWidth,
  parameter int NumProducts = DefNumProducts
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   product_valid,
  input  logic [ResultWidth-1:0] product,
  input  logic [AccWidth-1:0]    threshold,
  output logic                   busy,
  output logic                   done,
  output logic [AccWidth-1:0]    score,
  output logic                   is_cat,
  output logic                   overflow
);

  localparam int CntWidth = $clog2(NumProducts + 1);
  localparam logic [CntWidth-1:0] LastCount = CntWidth'(NumProducts - 1);

  acc_state_e           state_q, state_d;
  logic [AccWidth-1:0]  acc_q, acc_d;
  logic [CntWidth-1:0]  count_q, count_d;
  logic                 flag_q, flag_d;
  logic [AccWidth-1:0]  score_q, score_d;
  logic                 is_cat_q, is_cat_d;
  logic                 overflow_q, overflow_d;
  logic                 done_q, done_d;

  logic [AccWidth-1:0]  add_sum;
  logic                 add_carry;

  sat_adder #(
    .Width (AccWidth)
  ) u_sat_adder (
    .a     (acc_q),
    .b     (AccWidth'(product)),
    .sum   (add_sum),
    .carry (add_carry)
  );

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d    = state_q;
    acc_d      = acc_q;
    count_d    = count_q;
    flag_d     = flag_q;
    score_d    = score_q;
    is_cat_d   = is_cat_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          count_d = '0;
          flag_d  = 1'b0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        // A restart wins over a product presented in the same cycle.
        if (start) begin
          acc_d   = '0;
          count_d = '0;
          flag_d  = 1'b0;
        end else if (product_valid) begin
          acc_d   = add_sum;
          count_d = count_q + CntWidth'(1);
          if (add_carry) flag_d = 1'b1;
          if (count_q == LastCount) state_d = DECIDE;
        end
      end
      DECIDE: begin
        score_d    = acc_q;
        is_cat_d   = (acc_q >= threshold);
        overflow_d = flag_q;
        done_d     = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; the reset is asynchronous and active-low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      count_q    <= '0;
      flag_q     <= 1'b0;
      score_q    <= '0;
      is_cat_q   <= 1'b0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      flag_q     <= flag_d;
      score_q    <= score_d;
      is_cat_q   <= is_cat_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign score    = score_q;
  assign is_cat   = is_cat_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_cat_score_accumulator.sv
// Scoreboard bench: two accumulators (AccWidth 32 and 27, NumProducts 4) share
// the same stimulus; each frame pushes hand-computed results for both, and a
// negedge monitor pops and compares them whenever done is seen.
module tb_cat_score_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        product_valid;
  logic [26:0] product;
  logic [31:0] thr32;
  logic [26:0] thr27;

  logic        busy32, done32, is_cat32, ovf32;
  logic [31:0] score32;
  logic        busy27, done27, is_cat27, ovf27;
  logic [26:0] score27;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  cat_score_accumulator #(.AccWidth(32), .NumProducts(4)) dut32 (
    .clk(clk), .rst(rst), .start(start), .product_valid(product_valid),
    .product(product), .threshold(thr32), .busy(busy32), .done(done32),
    .score(score32), .is_cat(is_cat32), .overflow(ovf32)
  );

  cat_score_accumulator #(.AccWidth(27), .NumProducts(4)) dut27 (
    .clk(clk), .rst(rst), .start(start), .product_valid(product_valid),
    .product(product), .threshold(thr27), .busy(busy27), .done(done27),
    .score(score27), .is_cat(is_cat27), .overflow(ovf27)
  );

  typedef struct {
    logic [31:0] score;
    logic        is_cat;
    logic        ovf;
    int          dcyc;
  } exp_t;

  exp_t q32[$];
  exp_t q27[$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compares each done pulse against the oldest expected frame.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (done32 === 1'b1) begin
      if (q32.size() == 0) check("done32_unexpected", 64'(done32), 64'd0);
      else begin
        e = q32.pop_front();
        check("score32",     64'(score32),  64'(e.score));
        check("is_cat32",    64'(is_cat32), 64'(e.is_cat));
        check("overflow32",  64'(ovf32),    64'(e.ovf));
        check("done32_cyc",  64'(cyc),      64'(e.dcyc));
        check("busy32_done", 64'(busy32),   64'd0);
      end
    end
    if (done27 === 1'b1) begin
      if (q27.size() == 0) check("done27_unexpected", 64'(done27), 64'd0);
      else begin
        e = q27.pop_front();
        check("score27",     64'(score27),  64'(e.score));
        check("is_cat27",    64'(is_cat27), 64'(e.is_cat));
        check("overflow27",  64'(ovf27),    64'(e.ovf));
        check("done27_cyc",  64'(cyc),      64'(e.dcyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_thr(input logic [31:0] t);
    thr32 = t;
    thr27 = t[26:0];
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Presents one product for one cycle; c is the cycle count while it is driven.
  task automatic put(input logic [26:0] p, output int c);
    c             = cyc;
    product_valid = 1'b1;
    product       = p;
    tick();
    product_valid = 1'b0;
  endtask

  // Last product driven while cyc == c is accepted at edge c+1, done at edge c+2.
  task automatic push_exp(input int c,
                          input logic [31:0] s32, input logic c32, input logic o32,
                          input logic [31:0] s27, input logic c27, input logic o27);
    exp_t e;
    e.dcyc = c + 2;
    e.score = s32; e.is_cat = c32; e.ovf = o32; q32.push_back(e);
    e.score = s27; e.is_cat = c27; e.ovf = o27; q27.push_back(e);
  endtask

  task automatic run_frame(input logic [26:0] p0, p1, p2, p3, input int gap,
                           input logic [31:0] s32, input logic c32, input logic o32,
                           input logic [31:0] s27, input logic c27, input logic o27);
    logic [26:0] pv [4];
    int c;
    pv[0] = p0; pv[1] = p1; pv[2] = p2; pv[3] = p3;
    do_start();
    for (int i = 0; i < 4; i++) begin
      put(pv[i], c);
      if (i < 3) repeat (gap) tick();
    end
    push_exp(c, s32, c32, o32, s27, c27, o27);
  endtask

  initial begin
    int c;
    rst = 1'b0; start = 1'b0; product_valid = 1'b0; product = '0;
    set_thr(32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy32",  64'(busy32),   64'd0);
    check("rst_done32",  64'(done32),   64'd0);
    check("rst_score32", 64'(score32),  64'd0);
    check("rst_is_cat",  64'(is_cat32), 64'd0);
    check("rst_ovf32",   64'(ovf32),    64'd0);
    check("rst_score27", 64'(score27),  64'd0);
    rst = 1'b1;
    tick();

    // Frame 1: back-to-back, score equals threshold.
    set_thr(32'd100);
    do_start();
    check("busy_after_start", 64'(busy32), 64'd1);
    put(27'd10, c); put(27'd20, c); put(27'd30, c); put(27'd40, c);
    push_exp(c, 32'd100, 1'b1, 1'b0, 32'd100, 1'b1, 1'b0);
    repeat (4) tick();

    // Frame 2: threshold one above score, 3-cycle gaps.
    set_thr(32'd101);
    run_frame(27'd10, 27'd20, 27'd30, 27'd40, 3, 32'd100, 1'b0, 1'b0, 32'd100, 1'b0, 1'b0);
    repeat (4) tick();

    // Frame 3: 4 x 2^26 saturates the 27-bit accumulator only.
    set_thr(32'd100);
    run_frame(27'h4000000, 27'h4000000, 27'h4000000, 27'h4000000, 0,
              32'h1000_0000, 1'b1, 1'b0, 32'h07FF_FFFF, 1'b1, 1'b1);
    repeat (4) tick();

    // Frame 4: small values clear the overflow flag.
    run_frame(27'd1, 27'd2, 27'd3, 27'd4, 0, 32'd10, 1'b0, 1'b0, 32'd10, 1'b0, 1'b0);
    repeat (4) tick();

    // Frame 5: abort after two products, restart.
    set_thr(32'd10);
    do_start();
    put(27'd5, c); put(27'd5, c);
    run_frame(27'd1, 27'd2, 27'd3, 27'd4, 0, 32'd10, 1'b1, 1'b0, 32'd10, 1'b1, 1'b0);
    repeat (4) tick();

    // Reset mid-frame: outputs clear immediately, no done afterwards.
    do_start();
    put(27'd7, c); put(27'd8, c);
    #2 rst = 1'b0;
    #1;
    check("midrst_busy",   64'(busy32),   64'd0);
    check("midrst_score",  64'(score32),  64'd0);
    check("midrst_is_cat", 64'(is_cat32), 64'd0);
    check("midrst_done",   64'(done32),   64'd0);
    check("midrst_score27", 64'(score27), 64'd0);
    tick();
    rst = 1'b1;
    product_valid = 1'b1; product = 27'd9;
    repeat (3) tick();
    product_valid = 1'b0;
    repeat (4) tick();
    check("idle_ignores_valid", 64'(busy32), 64'd0);

    // Frame 7 then frame 8 started in the done cycle of frame 7.
    set_thr(32'd5);
    run_frame(27'd1, 27'd2, 27'd3, 27'd4, 0, 32'd10, 1'b1, 1'b0, 32'd10, 1'b1, 1'b0);
    tick();
    set_thr(32'd4);
    do_start();
    check("b2b_busy", 64'(busy32), 64'd1);
    put(27'd1, c); put(27'd1, c);
    check("score_hold", 64'(score32), 64'd10);
    put(27'd1, c); put(27'd1, c);
    push_exp(c, 32'd4, 1'b1, 1'b0, 32'd4, 1'b1, 1'b0);

    repeat (10) tick();
    check("q32_drained", 64'(q32.size()), 64'd0);
    check("q27_drained", 64'(q27.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cat_score_accumulator.md
# cat_score_accumulator

- Sequential stage directly downstream of the three-pixel/three-weight multiply-add block.
- Accumulates one frame's worth of row dot-products into a frame score, using a saturating adder.
- At end of frame, compares the score against a programmable threshold and registers a cat / not-cat decision with a one-cycle `done` pulse.
- Its output feeds the recognizer's top-level result logic.

## Interface

Parameters:
- `PixelWidth`, 8, pixel bit width (must match upstream)
- `WeightWidth`, 5, weight bit width (must match upstream)
- `ResultWidth`, 2*(WeightWidth+PixelWidth)+1, width of each incoming product sum (27 at defaults)
- `AccWidth`, 32, accumulator/score/threshold width; must be ≥ ResultWidth
- `NumProducts`, 4096, products per frame; must be ≥ 1

Ports:
- `clk` in 1 — single clock, rising edge
- `rst` in 1 — asynchronous, active-low reset
- `start` in 1 — begin new frame
- `product_valid` in 1 — `product` is valid this cycle
- `product` in ResultWidth — unsigned row dot-product from upstream
- `threshold` in AccWidth — unsigned decision threshold, sampled in DECIDE
- `busy` out 1 — high in ACCUM and DECIDE
- `done` out 1 — one-cycle pulse: `score`/`is_cat`/`overflow` just updated
- `score` out AccWidth — registered final frame score
- `is_cat` out 1 — registered decision, 1 when score ≥ threshold
- `overflow` out 1 — registered; frame saturated

## Operation

- FSM states: IDLE, ACCUM, DECIDE.
- IDLE:
  - `product_valid` is ignored.
  - `start`=1 → clear accumulator, count=0, clear frame overflow flag, go to ACCUM.
- ACCUM:
  - `product_valid`=1 → acc ← sat(acc + zero-extended product); count++.
  - If this is the NumProducts-th accepted product → go to DECIDE.
  - `product_valid`=0 → hold; gaps of any length are legal.
- ACCUM, `start`=1 → abort the frame and restart (clear acc, count, flag; stay in ACCUM).
  - A `product_valid` in the same cycle is discarded.
- DECIDE (one cycle):
  - `score` ← acc; `is_cat` ← (acc ≥ `threshold`); `overflow` ← frame flag; `done` ← 1; go to IDLE.
  - `start` and `product_valid` are ignored.
- Saturation:
  - If acc + product > 2^AccWidth−1, acc ← 2^AccWidth−1 and the frame flag is set.
  - The flag is sticky until the next start.
- All comparisons and additions are unsigned.
- `score`, `is_cat`, `overflow` hold their values until the next DECIDE; `start` does not clear them.
- Counter width is $clog2(NumProducts+1).

## Timing

- Reset values: state=IDLE; acc=0; count=0; `busy`=0; `done`=0; `score`=0; `is_cat`=0; `overflow`=0.
- Reset mid-frame aborts immediately and asynchronously to the reset values above; no `done` is generated.
- `start` sampled at edge t → `busy`=1 from t; the first product can be accepted at edge t+1.
- Last product accepted at edge k → DECIDE during cycle k..k+1 → at edge k+1, outputs update and `done`=1 for exactly one cycle.
  - Latency from last product to `done` visible: 2 edges (k, k+1).
- `busy` falls at edge k+1, together with `done` rising.
- A `start` in the `done` cycle (state IDLE) is accepted: back-to-back frames are allowed, with one dead cycle (DECIDE) between frames.
- NumProducts=1: start at t, product at t+1, `done` high after edge t+2.

## Structure

- Shared package `cat_recognizer_pkg`:
  - PixelWidth/WeightWidth/ResultWidth/AccWidth defaults
  - FSM state typedef (IDLE, ACCUM, DECIDE)
  - frame-size constant shared with the upstream row sequencer
- One sub-module: `sat_adder` — combinational AccWidth unsigned saturating add with a carry-out flag.
  - Used for the accumulator update.
- Remainder (FSM, counter, output registers) stays in this module.

## Test plan

Use NumProducts=4, AccWidth=32 unless stated.

- Reset, then start, then products 10, 20, 30, 40 back-to-back, threshold=100 → `done` pulse 2 edges after last product; score=100, is_cat=1, overflow=0.
- Same products with threshold=101 → is_cat=0.
  - Insert 3-cycle `product_valid` gaps between products → same score; `done` timing still measured from the last product.
- AccWidth=27, four products of 2^26 → acc saturates; score=2^27−1, overflow=1.
  - Next frame of small values → overflow=0.
- Start, 2 products (5, 5), then start again, then products 1, 2, 3, 4 → single `done`; score=10.
- Start, 2 products, then assert `rst` low mid-frame → all outputs 0 immediately; `product_valid` afterwards is ignored until start.
- Start asserted in the `done` cycle, next frame 1, 1, 1, 1 → second `done` with score=4.
  - `score` retains the first frame's value until then.
